// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with start-bit qualification, stop-bit check and a one-word output register.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 in,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic [2:0]           dbg_state
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || !(OVERSAMPLE inside {8, 16, 32}) ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_rx_param: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  state_t                 state;
  logic [1:0]             sync;
  logic                   in_s;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic                   stop_idx;
  logic                   stop_bad;
  logic [DATA_BITS-1:0]   shreg;
  logic                   fin;
  logic                   fin_ferr;
  logic                   tick;
  logic                   last_stop;
  logic                   ok;
  logic                   load;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad;
  logic                   fin_perr;
`endif

  assign in_s      = sync[1];
  assign tick      = (cnt == TICK_LAST);
  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
  assign dbg_state = state;

  // fin marks the cycle after the final stop sample; the result pulses are registered from it.
`ifdef UART_RX_PARITY_EN
  assign ok = fin && en && !fin_ferr && !fin_perr;
`else
  assign ok = fin && en && !fin_ferr;
  assign parity_err = 1'b0;
`endif
  assign load = ok && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      sync      <= 2'b11;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      stop_bad  <= 1'b0;
      shreg     <= '0;
      fin       <= 1'b0;
      fin_ferr  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      fin_perr   <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      sync      <= {sync[0], in};
      done      <= ok;
      frame_err <= fin && en && fin_ferr;
      overrun   <= ok && !load;
`ifdef UART_RX_PARITY_EN
      parity_err <= fin && en && !fin_ferr && fin_perr;
`endif
      if (load) begin
        out       <= shreg;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      fin <= 1'b0;

      if (!en) begin
        state <= ST_IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!in_s) begin
              if (cnt == HALF_LAST) begin
                cnt   <= '0;
                busy  <= 1'b1;
                state <= ST_START;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              cnt <= '0;
            end
          end
          // The end of the start-bit wait lands on the middle of data bit 0, so it is captured here.
          ST_START: begin
            if (tick) begin
              cnt     <= '0;
              shreg   <= {in_s, shreg[DATA_BITS-1:1]};
              bit_idx <= BW'(1);
              state   <= ST_DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (tick) begin
              cnt   <= '0;
              shreg <= {in_s, shreg[DATA_BITS-1:1]};
              if (bit_idx == BIT_LAST) begin
                stop_idx <= 1'b0;
                stop_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
                state    <= ST_PARITY;
`else
                state    <= ST_STOP;
`endif
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (tick) begin
              cnt     <= '0;
              par_bad <= in_s != ((^shreg) ^ 1'(PARITY_ODD));
              state   <= ST_STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif
          ST_STOP: begin
            if (tick) begin
              cnt <= '0;
              if (last_stop) begin
                state    <= ST_IDLE;
                busy     <= 1'b0;
                fin      <= 1'b1;
                fin_ferr <= stop_bad | !in_s;
`ifdef UART_RX_PARITY_EN
                fin_perr <= par_bad;
`endif
              end else begin
                stop_idx <= 1'b1;
                stop_bad <= stop_bad | !in_s;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed and randomized frames checked against a frame-level model of the receiver
// (outcome per frame, output word register, done latency).
module tb_uart_rx_param;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int SB = 1;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAT = (1 + DB + PB + SB) * OS - OS / 2 + 2;

  logic          clk;
  logic          reset;
  logic          en;
  logic          in;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic [DB-1:0] out;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  logic [2:0]    dbg_state;

  uart_rx_param #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS),
    .STOP_BITS (SB),
    .PARITY_ODD(0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in        (in),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out       (out),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor, sampled on the falling edge
  int n_done = 0, n_ferr = 0, n_perr = 0, n_ovr = 0, n_busy = 0, done_cyc = 0;
  always @(negedge clk) begin
    if (done)       n_done   <= n_done + 1;
    if (done)       done_cyc <= cyc;
    if (frame_err)  n_ferr   <= n_ferr + 1;
    if (parity_err) n_perr   <= n_perr + 1;
    if (overrun)    n_ovr    <= n_ovr + 1;
    if (busy)       n_busy   <= n_busy + 1;
  end

  // scoreboard: words delivered but not yet consumed, plus the value out must hold
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] exp_out = '0;
  int total = 0;
  int bad   = 0;
  bit bad_par_v = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic drive_bit(input logic b, input int n);
    in = b;
    repeat (n) @(negedge clk);
  endtask

  // A bad stop bit is held low only for 3/4 of the bit so the tail cannot look like a new start.
  task automatic send_frame(input logic [DB-1:0] d, input bit bad_stop, output int t0);
    t0 = cyc + 1;
    drive_bit(1'b0, OS);
    for (int i = 0; i < DB; i++) drive_bit(d[i], OS);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ bad_par_v, OS);
`endif
    for (int s = 0; s < SB; s++) begin
      if (bad_stop && s == SB - 1) begin
        drive_bit(1'b0, OS * 3 / 4);
        drive_bit(1'b1, OS / 4);
      end else begin
        drive_bit(1'b1, OS);
      end
    end
  endtask

  task automatic run_frame(input logic [DB-1:0] d, input bit bad_stop, input bit bad_par);
    int d0, f0, p0, o0, t0;
    bit exp_ferr, exp_perr, good, exp_ovr;
    d0 = n_done; f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
    bad_par_v = bad_par;
    send_frame(d, bad_stop, t0);
    #1;
    exp_ferr = bad_stop;
    exp_perr = !bad_stop && bad_par && (PB == 1);
    good     = !exp_ferr && !exp_perr;
    exp_ovr  = good && (exp_q.size() != 0);
    chk("done_count", n_done - d0, good);
    chk("frame_err_count", n_ferr - f0, exp_ferr);
    chk("parity_err_count", n_perr - p0, exp_perr);
    chk("overrun_count", n_ovr - o0, exp_ovr);
    if (good && !exp_ovr) begin
      exp_q.push_back(d);
      exp_out = d;
    end
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("out", out, exp_out);
    chk("busy_after", busy, 0);
    if (good) chk("done_latency", done_cyc - t0, LAT);
  endtask

  task automatic consume();
    logic [DB-1:0] w;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      chk("consume_word", out, w);
    end
    chk("out_valid_cleared", out_valid, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_out = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, f0, p0, o0, b0;
    in = 1'b1; en = 1'b1; out_ready = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // single frame and latency
    run_frame(8'hA5, 1'b0, 1'b0);
    consume();

    // short low glitch while idle
    d0 = n_done; f0 = n_ferr; p0 = n_perr; o0 = n_ovr; b0 = n_busy;
    drive_bit(1'b0, 6);
    drive_bit(1'b1, 40);
    #1;
    chk("glitch_busy", n_busy - b0, 0);
    chk("glitch_pulses", (n_done - d0) + (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);
    chk("glitch_out_valid", out_valid, 0);

    // back-to-back frames without consuming: second one overruns
    run_frame(8'h3C, 1'b0, 1'b0);
    run_frame(8'hC3, 1'b0, 1'b0);
    consume();

    // stop-bit error leaves the held word alone
    run_frame(8'h11, 1'b0, 1'b0);
    run_frame(8'h55, 1'b1, 1'b0);
    consume();

`ifdef UART_RX_PARITY_EN
    run_frame(8'h07, 1'b0, 1'b1);
`endif

    // enable dropped mid-frame
    run_frame(8'h6E, 1'b0, 1'b0);
    d0 = n_done; f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
    drive_bit(1'b0, OS);
    drive_bit(1'b0, OS * 2);
    en = 1'b0;
    drive_bit(1'b1, 3);
    #1;
    chk("abort_busy", busy, 0);
    drive_bit(1'b1, OS * 2);
    en = 1'b1;
    drive_bit(1'b1, OS * 12);
    #1;
    chk("abort_pulses", (n_done - d0) + (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);
    chk("abort_out_valid", out_valid, exp_q.size() != 0);
    chk("abort_out", out, exp_out);
    consume();

    // reset in the middle of data bit 4, then a clean frame
    run_frame(8'h5A, 1'b0, 1'b0);
    d0 = n_done; f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
    drive_bit(1'b0, OS);
    drive_bit(1'b1, OS * 4);
    drive_bit(1'b0, OS / 2);
    #1;
    chk("midframe_busy", busy, 1);
    do_reset();
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_out", out, 0);
    drive_bit(1'b1, OS * 2);
    #1;
    chk("post_rst_pulses", (n_done - d0) + (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);
    run_frame(8'h81, 1'b0, 1'b0);
    consume();

    // randomized frames, errors, consumption and gaps
    for (int i = 0; i < 20; i++) begin
      logic [DB-1:0] d;
      int kind, gap;
      d    = DB'($urandom_range(0, (1 << DB) - 1));
      kind = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) consume();
      gap = $urandom_range(0, 2);
      if (gap != 0) drive_bit(1'b1, gap * OS);
      run_frame(d, kind == 0, kind == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, clk ticks per baud interval, legal 8, 16 or 32.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame, legal 1 or 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0, parity sense (0 even, 1 odd); used only with UART_RX_PARITY_EN.
REQ-005 SHALL have port clk  input  1  rx sampling clock at OVERSAMPLE x baud; single clock domain.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  receive enable.
REQ-008 SHALL have port in  input  1  asynchronous rx line, idle high.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out this cycle.
REQ-010 SHALL have port busy  output  1  frame in progress.
REQ-011 SHALL have port done  output  1  one-clk pulse, frame received without error.
REQ-012 SHALL have port out_valid  output  1  out holds unconsumed data.
REQ-013 SHALL have port out  output  DATA_BITS  received data, LSB first on the line.
REQ-014 SHALL have port frame_err  output  1  one-clk pulse, stop bit sampled low.
REQ-015 SHALL have port parity_err  output  1  one-clk pulse, parity mismatch; tied 0 without UART_RX_PARITY_EN.
REQ-016 SHALL have port overrun  output  1  one-clk pulse, completed frame dropped because out_valid was still set.

Function
REQ-017 SHALL double-register in; only the synchronised sample (in_s) drives logic.
REQ-018 SHALL implement states IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT, with a tick counter of width log2(OVERSAMPLE).
REQ-019 IDLE: SHALL count consecutive low in_s; at count OVERSAMPLE/2-1 SHALL clear the counter, set busy and enter START_BIT; in_s high before that SHALL clear the counter with no error.
REQ-020 START_BIT: SHALL wait OVERSAMPLE ticks to the first data bit mid-point, then enter DATA_BITS.
REQ-021 DATA_BITS: SHALL sample in_s every OVERSAMPLE ticks into bit index 0..DATA_BITS-1; after the last bit SHALL enter PARITY_BIT if parity is compiled in, else STOP_BIT.
REQ-022 PARITY_BIT: SHALL sample one bit and compare it with the XOR of the data bits, inverted when PARITY_ODD=1.
REQ-023 STOP_BIT: SHALL sample STOP_BITS bits OVERSAMPLE ticks apart; any low sample sets the frame error condition.
REQ-024 Completion at the final stop-bit sample: SHALL clear busy, return to IDLE and, in the following cycle, pulse exactly one of done, frame_err or parity_err (frame_err takes priority).
REQ-025 On done: if out_valid=0, or out_valid=1 and out_ready=1 in the same cycle, SHALL load out and set out_valid; otherwise SHALL keep out unchanged and pulse overrun.
REQ-026 A frame with an error SHALL NOT load out or change out_valid.
REQ-027 SHALL clear out_valid on any cycle with out_valid=1 and out_ready=1 and no simultaneous load; out SHALL hold its value until the next load.
REQ-028 SHALL accept a new start edge in IDLE in the cycle immediately after completion, allowing back-to-back frames.
REQ-029 en low SHALL abort any frame in progress: next state IDLE, busy 0, no pulses; out and out_valid SHALL be unaffected.
REQ-030 done latency SHALL be (1+DATA_BITS+P+STOP_BITS)*OVERSAMPLE - OVERSAMPLE/2 + 2 clk after the first edge sampling in low, where P=1 with parity and 0 otherwise.

Reset
REQ-031 reset SHALL take priority over en and all other inputs.
REQ-032 reset SHALL set state IDLE, all counters 0, the synchroniser to 2'b11, and busy, done, out_valid, frame_err, parity_err and overrun to 0, and out to 0.
REQ-033 reset asserted mid-frame SHALL discard the frame with no output pulse.

Configuration
REQ-034 With macro UART_RX_PARITY_EN defined: PARITY_BIT state present, parity checked per REQ-022, parity_err driven.
REQ-035 Without UART_RX_PARITY_EN: PARITY_BIT state and parity logic absent, frame is start/data/stop only, parity_err tied 0.

Verification
REQ-036 8N1, OVERSAMPLE=16, frame 0xA5 -> done pulse 154 clk after the first low sample, out=0xA5, out_valid=1.
REQ-037 Low glitch of 6 clk on in while idle -> busy stays 0, no pulses, no state change.
REQ-038 Two back-to-back frames 0x3C and 0xC3 with out_ready held 0 -> out=0x3C, overrun pulses once on the second frame.
REQ-039 Stop bit driven low for frame 0x55 -> frame_err pulses, done stays 0, out and out_valid unchanged.
REQ-040 With UART_RX_PARITY_EN, PARITY_ODD=0, frame 0x07 sent with parity bit 0 -> parity_err pulses, no load.
REQ-041 reset asserted at data bit 4 of a frame, then frame 0x81 sent -> only 0x81 is delivered, with one done pulse.
